// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the program ROM: fetches one instruction, then executes it
// as a one-cycle strobe phase. Handles free-run and single-step operation.
module fetch_sequencer #(
  parameter int AW = 4,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          step,
  input  logic          zero_flag,
  input  logic [IW-1:0] instruction,
  output logic [AW-1:0] rom_addr,
  output logic [IW-1:0] ir,
  output logic [2:0]    rd_sel,
  output logic [2:0]    rs_sel,
  output logic [7:0]    imm,
  output logic [1:0]    alu_op,
  output logic          alu_src_imm,
  output logic          reg_we,
  output logic          out_we,
  output logic          retired
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;

  // Opcode classes, indexed by ir[15:12]
  localparam logic [15:0] WRITES_REG = 16'b0100_1000_0000_1110;
  localparam logic [15:0] USES_IMM   = 16'b0000_1000_0000_0010;

  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_SUBI = 4'hB;
  localparam logic [3:0] OP_BR   = 4'hC;
  localparam logic [3:0] OP_MOV  = 4'hE;
  localparam logic [3:0] OP_OUT  = 4'hF;

  logic [1:0]    state_reg, state_next;
  logic [AW-1:0] pc_reg, pc_next;
  logic [IW-1:0] ir_reg, ir_next;
  logic          step_q_reg;
  logic          step_edge;
  logic          in_exec;
  logic [3:0]    opcode;
  logic [AW-1:0] target_pc;

  assign step_edge = step & ~step_q_reg;
  assign in_exec   = (state_reg == EXEC);
  assign opcode    = ir_reg[IW-1 -: 4];

  // zero_flag only matters while a br is executing, since target_pc is consumed in EXEC only
  always_comb begin
    target_pc = pc_reg + AW'(1);
    if (opcode == OP_JMP || (opcode == OP_BR && zero_flag)) begin
      target_pc = AW'(ir_reg[11:8]);
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    case (state_reg)
      IDLE: begin
        if (run || step_edge) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        ir_next    = instruction;
        state_next = EXEC;
      end
      EXEC: begin
        pc_next    = target_pc;
        state_next = run ? FETCH : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      pc_reg     <= '0;
      ir_reg     <= '0;
      step_q_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      ir_reg     <= ir_next;
      step_q_reg <= step;
    end
  end

  always_comb begin
    reg_we      = in_exec & WRITES_REG[opcode];
    out_we      = in_exec & (opcode == OP_OUT);
    alu_src_imm = in_exec & USES_IMM[opcode];
    retired     = in_exec;
    alu_op      = 2'b00;
    if (in_exec) begin
      case (opcode)
        OP_ADD:                 alu_op = 2'b01;
        OP_SUB, OP_SUBI:        alu_op = 2'b10;
        OP_MOV, OP_OUT:         alu_op = 2'b11;
        default:                alu_op = 2'b00;
      endcase
    end
  end

  assign rom_addr = pc_reg;
  assign ir       = ir_reg;
  assign rd_sel   = ir_reg[11:9];
  assign rs_sel   = ir_reg[8:6];
  assign imm      = ir_reg[7:0];

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed program walk, single-step checks, then a
// randomized run/step/reset soak against an instruction-timeline reference model.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        run;
  logic        step;
  logic        zero_flag;
  logic [15:0] instruction;
  logic [3:0]  rom_addr;
  logic [15:0] ir;
  logic [2:0]  rd_sel;
  logic [2:0]  rs_sel;
  logic [7:0]  imm;
  logic [1:0]  alu_op;
  logic        alu_src_imm;
  logic        reg_we;
  logic        out_we;
  logic        retired;

  logic [15:0] rom [16];
  int checks;
  int failures;

  assign instruction = rom[rom_addr];

  fetch_sequencer #(.AW(4), .IW(16)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .zero_flag(zero_flag),
    .instruction(instruction), .rom_addr(rom_addr), .ir(ir), .rd_sel(rd_sel),
    .rs_sel(rs_sel), .imm(imm), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .reg_we(reg_we), .out_we(out_we), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {reg_we, out_we, alu_op[1:0], alu_src_imm} straight from the opcode table
  function automatic logic [4:0] ref_decode(input logic [15:0] i);
    case (i[15:12])
      4'h1:    return 5'b1_0_00_1;
      4'h2:    return 5'b1_0_01_0;
      4'h3:    return 5'b1_0_10_0;
      4'hB:    return 5'b1_0_10_1;
      4'hE:    return 5'b1_0_11_0;
      4'hF:    return 5'b0_1_00_0;
      default: return 5'b0_0_00_0;
    endcase
  endfunction

  function automatic logic [3:0] ref_next_pc(input logic [15:0] i, input logic [3:0] pc,
                                             input logic zf);
    if (i[15:12] == 4'h8) return i[11:8];
    if (i[15:12] == 4'hC && zf) return i[11:8];
    return pc + 4'd1;
  endfunction

  initial begin
    int pulses;
    logic [3:0] ops [12];
    int mode;
    int edge_n;
    int due;
    bit active;
    logic [3:0] mpc;
    logic sprev;
    logic rv, rn, st, zf;
    bit exp_ret;
    logic [15:0] ei;
    logic [4:0] ed;

    checks = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    rom[0]  = 16'h1E07;
    rom[2]  = 16'hCA00;
    rom[3]  = 16'hFE00;
    rom[4]  = 16'h8100;
    rom[10] = 16'h8F00;

    // reset behaviour
    rst = 1'b1; run = 1'b0; step = 1'b0; zero_flag = 1'b0;
    tick(); tick();
    check("rst_addr", 32'(rom_addr), 0);
    check("rst_ir", 32'(ir), 0);
    check("rst_strobes", 32'({reg_we, out_we, retired}), 0);
    rst = 1'b0;
    tick(); tick();
    check("idle_retired", 32'(retired), 0);
    check("idle_addr", 32'(rom_addr), 0);

    // free-run walk through the directed program
    run = 1'b1;
    tick();
    check("fetch_no_retire", 32'(retired), 0);
    tick();
    check("load_retired", 32'(retired), 1);
    check("load_reg_we", 32'(reg_we), 1);
    check("load_rd_sel", 32'(rd_sel), 7);
    check("load_imm", 32'(imm), 7);
    check("load_alu_op", 32'(alu_op), 0);
    check("load_src_imm", 32'(alu_src_imm), 1);
    tick(); check("pc_after_load", 32'(rom_addr), 1);
    tick(); check("nop_reg_we", 32'(reg_we), 0);
    tick(); check("pc_after_nop", 32'(rom_addr), 2);
    zero_flag = 1'b0;
    tick(); check("br_retired", 32'(retired), 1);
    tick(); check("br_not_taken", 32'(rom_addr), 3);
    tick(); check("out_out_we", 32'(out_we), 1); check("out_reg_we", 32'(reg_we), 0);
    tick(); check("pc_after_out", 32'(rom_addr), 4);
    tick();
    tick(); check("jmp_target", 32'(rom_addr), 1);
    tick();
    tick(); check("pc_to_br", 32'(rom_addr), 2);
    zero_flag = 1'b1;
    tick();
    tick(); check("br_taken", 32'(rom_addr), 10);
    zero_flag = 1'b0;
    tick();
    tick(); check("jmp_to_15", 32'(rom_addr), 15);
    tick();
    tick(); check("pc_wrap", 32'(rom_addr), 0);
    tick(); check("exec_before_rst", 32'(retired), 1);
    rst = 1'b1; run = 1'b0;
    tick();
    check("rst_exec_strobes", 32'({reg_we, out_we, retired}), 0);
    check("rst_exec_addr", 32'(rom_addr), 0);
    rst = 1'b0;
    tick();

    // single step: held step gives exactly one instruction
    step = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin tick(); pulses += int'(retired); end
    check("step1_pulses", 32'(pulses), 1);
    check("step1_idle", 32'(retired), 0);
    check("step1_addr", 32'(rom_addr), 1);
    step = 1'b0;
    tick(); tick();
    step = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin tick(); pulses += int'(retired); end
    check("step2_pulses", 32'(pulses), 1);
    check("step2_addr", 32'(rom_addr), 2);
    step = 1'b0;

    // randomized soak: the model tracks the PC and the cycle at which the next retire is due
    ops = '{4'h1, 4'h2, 4'h3, 4'hB, 4'hE, 4'hF, 4'h8, 4'hC, 4'h0, 4'h4, 4'h7, 4'hD};
    for (int i = 0; i < 16; i++) begin
      rom[i] = {ops[$urandom_range(0, 11)], 12'($urandom_range(0, 4095))};
    end
    edge_n = 0; due = 0; active = 1'b0; mpc = 4'd0; sprev = 1'b0; mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 50 == 0) mode = $urandom_range(0, 2);
      rst = (c < 2) || ($urandom_range(0, 199) == 0);
      case (mode)
        0:       run = 1'b1;
        1:       run = ($urandom_range(0, 3) != 0);
        default: run = ($urandom_range(0, 15) == 0);
      endcase
      step = 1'($urandom_range(0, 1));
      zero_flag = 1'($urandom_range(0, 1));
      rv = rst; rn = run; st = step; zf = zero_flag;
      tick();
      edge_n++;
      if (rv) begin
        active = 1'b0; mpc = 4'd0; sprev = 1'b0;
      end else begin
        if (active && (edge_n - 1 == due)) begin
          mpc = ref_next_pc(rom[mpc], mpc, zf);
          if (rn) due = edge_n + 1;
          else active = 1'b0;
        end else if (!active && (rn || (st && !sprev))) begin
          active = 1'b1;
          due = edge_n + 1;
        end
        sprev = st;
      end
      exp_ret = active && (edge_n == due);
      check("rnd_addr", 32'(rom_addr), 32'(mpc));
      check("rnd_retired", 32'(retired), 32'(exp_ret));
      if (exp_ret) begin
        ei = rom[mpc];
        ed = ref_decode(ei);
        check("rnd_ir", 32'(ir), 32'(ei));
        check("rnd_reg_we", 32'(reg_we), 32'(ed[4]));
        check("rnd_out_we", 32'(out_we), 32'(ed[3]));
        check("rnd_fields", 32'({rd_sel, rs_sel, imm}), 32'({ei[11:9], ei[8:6], ei[7:0]}));
        if (ed[4]) begin
          check("rnd_alu_op", 32'(alu_op), 32'(ed[2:1]));
          check("rnd_src_imm", 32'(alu_src_imm), 32'(ed[0]));
        end
      end else begin
        check("rnd_quiet", 32'({reg_we, out_we}), 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
